id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- Pipeline register between the ID stage (register file, decoder, sign-extender) and the EX stage of the 5-stage MIPS core.
- Captures operands, immediate, register specifiers and control bits each cycle.
- Detects load-use hazards and inserts bubbles on hazard or branch flush.
- Bypasses same-edge WB writes that the register file's negedge read misses.

Parameters:
- DATA_W, 32, datapath width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, width of saturating bubble counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc_plus4  in  DATA_W  PC+4 of ID instruction
- id_read_data1  in  DATA_W  register file ReadData1
- id_read_data2  in  DATA_W  register file ReadData2
- id_imm_ext  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_uses_rt  in  1  instruction reads rt as a source
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  control
- id_alu_op  in  ALUOP_W  ALU control
- wb_reg_write  in  1  WB writes register file this edge
- wb_write_register  in  5  WB destination
- wb_write_data  in  DATA_W  WB data
- flush  in  1  branch taken; squash ID instruction
- ex_hold  in  1  EX cannot accept; freeze contents
- ex_valid  out  1  EX slot holds real instruction
- ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext  out  DATA_W  registered copies
- ex_rs, ex_rt, ex_rd  out  5 each
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst  out  1 each
- ex_alu_op  out  ALUOP_W
- id_stall  out  1  combinational; freeze PC and IF/ID
- bubble_count  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (rst=0 at rising edge): all ex_* outputs 0, ex_valid=0, bubble_count=0. id_stall is forced 0 while rst=0.
- load_use (combinational) = ex_valid & ex_mem_read & ex_rt!=0 & id_valid & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- id_stall = load_use | ex_hold.
- Per-edge priority: reset > flush > ex_hold > load_use > capture.
- flush: bubble. ex_valid=0; all control bits and ex_alu_op=0; data and specifier fields don't-care (implement as hold). bubble_count += 1. Flush overrides ex_hold.
- ex_hold (no flush): all fields keep their values, with one exception. If ex_valid & wb_reg_write & wb_write_register!=0:
  - wb_write_register==ex_rs: ex_read_data1 <= wb_write_data.
  - wb_write_register==ex_rt: ex_read_data2 <= wb_write_data.
- load_use (no flush, no hold): bubble as for flush; bubble_count += 1. The ID instruction stays in ID (upstream frozen by id_stall) and is captured one cycle later, when load_use has cleared.
- capture: all fields <= id_*; ex_valid <= id_valid.
  - Operand 1 <= wb_write_data if wb_reg_write & wb_write_register!=0 & wb_write_register==id_rs; else id_read_data1.
  - Operand 2: same rule against id_rt.
  - Register 0 is never bypassed.
- id_valid=0 on capture: control bits are still captured as given; ex_valid=0 makes the instruction a no-op downstream. Not counted as a bubble.
- bubble_count saturates at all-ones; no wrap.
- Latency: one cycle ID->EX.
- Reset mid-hold or mid-bubble: reset wins, and the next cycle starts empty.

Decomposition:
- Shared package: DATA_W, ALUOP_W, REG_ZERO=5'd0, ALU op encodings.
- One natural sub-module, hazard_detect: the combinational load_use/id_stall logic, reusable by the IF/ID register.

Test Plan:
1. Plain capture: rst released, id_valid=1, id_read_data1=32'h11, id_read_data2=32'h22, id_alu_op=4'h2 -> next edge ex_read_data1=32'h11, ex_read_data2=32'h22, ex_alu_op=4'h2, ex_valid=1, id_stall=0.
2. Load-use: EX holds lw with ex_rt=8, ID presents add with id_rs=8:
   - id_stall=1 in same cycle; next edge ex_valid=0, ex_reg_write=0, bubble_count=1.
   - Following edge captures the add, id_stall=0.
   - Repeat with ex_rt=0 -> no stall.
3. WB bypass: id_rs=9, id_read_data1=32'h0, wb_reg_write=1, wb_write_register=9, wb_write_data=32'hDEAD -> ex_read_data1=32'hDEAD. Same case with wb_write_register=0 -> 32'h0.
4. Hold refresh: ex_hold=1 for 3 cycles with ex_rs=10; WB writes r10=32'h5 in cycle 2 -> ex_read_data1=32'h5, other fields unchanged, id_stall=1 throughout.
5. Flush priority: flush=1 with ex_hold=1 and load_use=1 simultaneously -> bubble, bubble_count increments exactly once.
6. Reset mid-hold: rst=0 while ex_hold=1 -> all outputs 0, bubble_count=0. Counter saturation with CNT_W=2: 5 bubbles -> bubble_count=3.

Source files
------------

// File: rtl/id_ex_register_pkg.sv
// Shared widths, register-zero constant, ALU op encodings and the WB bypass helper
// for the ID/EX pipeline register.
package id_ex_register_pkg;

   localparam int DATA_W  = 32;
   localparam int ALUOP_W = 4;
   localparam int REG_W   = 5;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_AND = 4'h0,
      ALU_OR  = 4'h1,
      ALU_ADD = 4'h2,
      ALU_SUB = 4'h6,
      ALU_SLT = 4'h7,
      ALU_NOR = 4'hC
   } aluOp_e;

   typedef struct packed {
      logic               regWrite;
      logic               memToReg;
      logic               memRead;
      logic               memWrite;
      logic               branch;
      logic               aluSrc;
      logic               regDst;
      logic [ALUOP_W-1:0] aluOp;
   } ctrl_t;

   // A WB write lands on the same edge the register file is read on its negedge,
   // so the stale read value must be replaced; register 0 is hard-wired and never bypassed.
   function automatic logic [DATA_W-1:0] bypass(
      input logic              wbWe,
      input logic [REG_W-1:0]  wbReg,
      input logic [DATA_W-1:0] wbData,
      input logic [REG_W-1:0]  srcReg,
      input logic [DATA_W-1:0] rfData
   );
      return (wbWe && (wbReg != REG_ZERO) && (wbReg == srcReg)) ? wbData : rfData;
   endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// ID/EX stage bundle: decoded ID fields, WB write-back snoop, flow control and EX-side copies.
interface id_ex_register_if;
   import id_ex_register_pkg::*;

   logic               id_valid;
   logic [DATA_W-1:0]  id_pc_plus4;
   logic [DATA_W-1:0]  id_read_data1;
   logic [DATA_W-1:0]  id_read_data2;
   logic [DATA_W-1:0]  id_imm_ext;
   logic [REG_W-1:0]   id_rs, id_rt, id_rd;
   logic               id_uses_rt;
   logic               id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write;
   logic               id_branch, id_alu_src, id_reg_dst;
   logic [ALUOP_W-1:0] id_alu_op;

   logic               wb_reg_write;
   logic [REG_W-1:0]   wb_write_register;
   logic [DATA_W-1:0]  wb_write_data;

   logic               flush;
   logic               ex_hold;

   logic               ex_valid;
   logic [DATA_W-1:0]  ex_pc_plus4;
   logic [DATA_W-1:0]  ex_read_data1;
   logic [DATA_W-1:0]  ex_read_data2;
   logic [DATA_W-1:0]  ex_imm_ext;
   logic [REG_W-1:0]   ex_rs, ex_rt, ex_rd;
   logic               ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
   logic               ex_branch, ex_alu_src, ex_reg_dst;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic               id_stall;

   modport master (
      output id_valid, id_pc_plus4, id_read_data1, id_read_data2, id_imm_ext,
             id_rs, id_rt, id_rd, id_uses_rt,
             id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
             id_branch, id_alu_src, id_reg_dst, id_alu_op,
             wb_reg_write, wb_write_register, wb_write_data, flush, ex_hold,
      input  ex_valid, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext,
             ex_rs, ex_rt, ex_rd,
             ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
             ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, id_stall
   );

   modport slave (
      input  id_valid, id_pc_plus4, id_read_data1, id_read_data2, id_imm_ext,
             id_rs, id_rt, id_rd, id_uses_rt,
             id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
             id_branch, id_alu_src, id_reg_dst, id_alu_op,
             wb_reg_write, wb_write_register, wb_write_data, flush, ex_hold,
      output ex_valid, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm_ext,
             ex_rs, ex_rt, ex_rd,
             ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
             ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, id_stall
   );

endinterface

// File: rtl/id_ex_register_hazard_detect.sv
// Load-use hazard detection and upstream stall; shared with the IF/ID register.
module id_ex_register_hazard_detect
   import id_ex_register_pkg::*;
(
   input  logic             rst,
   input  logic             exValid,
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exRt,
   input  logic             idValid,
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             idUsesRt,
   input  logic             exHold,
   output logic             loadUse,
   output logic             idStall
);

   always_comb begin
      loadUse = exValid && exMemRead && (exRt != REG_ZERO) && idValid &&
                ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
      idStall = rst && (loadUse || exHold);
   end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and WB bypass.
module id_ex_register
   import id_ex_register_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   id_ex_register_if.slave  bus,
   output logic [CNT_W-1:0] bubble_count
);

   logic              exValid;
   ctrl_t             exCtrl;
   logic [DATA_W-1:0] exPc, exRd1, exRd2, exImm;
   logic [REG_W-1:0]  exRs, exRt, exRd;
   logic [CNT_W-1:0]  bubbleCnt;
   logic              loadUse;
   logic              insertBubble;

   id_ex_register_hazard_detect hazardDetect (
      .rst       (rst),
      .exValid   (exValid),
      .exMemRead (exCtrl.memRead),
      .exRt      (exRt),
      .idValid   (bus.id_valid),
      .idRs      (bus.id_rs),
      .idRt      (bus.id_rt),
      .idUsesRt  (bus.id_uses_rt),
      .exHold    (bus.ex_hold),
      .loadUse   (loadUse),
      .idStall   (bus.id_stall)
   );

   // Flush and load-use produce the same bubble; folding them here keeps
   // the flush > hold > load-use priority in a single if-chain below.
   assign insertBubble = bus.flush || (!bus.ex_hold && loadUse);

   always_ff @(posedge clk) begin
      if (!rst) begin
         exValid   <= 1'b0;
         exCtrl    <= '0;
         exPc      <= '0;
         exRd1     <= '0;
         exRd2     <= '0;
         exImm     <= '0;
         exRs      <= '0;
         exRt      <= '0;
         exRd      <= '0;
         bubbleCnt <= '0;
      end else if (insertBubble) begin
         exValid <= 1'b0;
         exCtrl  <= '0;
         if (bubbleCnt != '1)
            bubbleCnt <= bubbleCnt + CNT_W'(1);
      end else if (bus.ex_hold) begin
         if (exValid) begin
            exRd1 <= bypass(bus.wb_reg_write, bus.wb_write_register, bus.wb_write_data, exRs, exRd1);
            exRd2 <= bypass(bus.wb_reg_write, bus.wb_write_register, bus.wb_write_data, exRt, exRd2);
         end
      end else begin
         exValid <= bus.id_valid;
         exCtrl  <= '{regWrite: bus.id_reg_write, memToReg: bus.id_mem_to_reg,
                      memRead:  bus.id_mem_read,  memWrite: bus.id_mem_write,
                      branch:   bus.id_branch,    aluSrc:   bus.id_alu_src,
                      regDst:   bus.id_reg_dst,   aluOp:    bus.id_alu_op};
         exPc    <= bus.id_pc_plus4;
         exRd1   <= bypass(bus.wb_reg_write, bus.wb_write_register, bus.wb_write_data,
                           bus.id_rs, bus.id_read_data1);
         exRd2   <= bypass(bus.wb_reg_write, bus.wb_write_register, bus.wb_write_data,
                           bus.id_rt, bus.id_read_data2);
         exImm   <= bus.id_imm_ext;
         exRs    <= bus.id_rs;
         exRt    <= bus.id_rt;
         exRd    <= bus.id_rd;
      end
   end

   assign bus.ex_valid      = exValid;
   assign bus.ex_pc_plus4   = exPc;
   assign bus.ex_read_data1 = exRd1;
   assign bus.ex_read_data2 = exRd2;
   assign bus.ex_imm_ext    = exImm;
   assign bus.ex_rs         = exRs;
   assign bus.ex_rt         = exRt;
   assign bus.ex_rd         = exRd;
   assign bus.ex_reg_write  = exCtrl.regWrite;
   assign bus.ex_mem_to_reg = exCtrl.memToReg;
   assign bus.ex_mem_read   = exCtrl.memRead;
   assign bus.ex_mem_write  = exCtrl.memWrite;
   assign bus.ex_branch     = exCtrl.branch;
   assign bus.ex_alu_src    = exCtrl.aluSrc;
   assign bus.ex_reg_dst    = exCtrl.regDst;
   assign bus.ex_alu_op     = exCtrl.aluOp;
   assign bubble_count      = bubbleCnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: expectations queued when stimulus is driven,
// compared one cycle later; a 2-bit-counter instance covers bubble saturation.
module tb_id_ex_register;
   import id_ex_register_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rstS;
   logic [15:0] bubbleCount;
   logic [1:0]  bubbleCountS;

   id_ex_register_if bus ();
   id_ex_register_if busS ();

   id_ex_register #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .bubble_count(bubbleCount)
   );

   id_ex_register #(.CNT_W(2)) dutSat (
      .clk(clk), .rst(rstS), .bus(busS), .bubble_count(bubbleCountS)
   );

   typedef enum int {S_VALID, S_RD1, S_RD2, S_ALUOP, S_REGW, S_MEMR, S_RS, S_RT, S_PC, S_BUB, S_BUBSAT} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   vecCount  = 0;
   int   missCount = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         S_VALID: return 32'(bus.ex_valid);
         S_RD1:   return bus.ex_read_data1;
         S_RD2:   return bus.ex_read_data2;
         S_ALUOP: return 32'(bus.ex_alu_op);
         S_REGW:  return 32'(bus.ex_reg_write);
         S_MEMR:  return 32'(bus.ex_mem_read);
         S_RS:    return 32'(bus.ex_rs);
         S_RT:    return 32'(bus.ex_rt);
         S_PC:    return bus.ex_pc_plus4;
         S_BUB:   return 32'(bubbleCount);
         S_BUBSAT: return 32'(bubbleCountS);
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic expectOut(input string tag, input sel_e s, input logic [31:0] v);
      exp_t e;
      e.tag   = tag;
      e.sel   = s;
      e.value = v;
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checkVal(e.tag, observe(e.sel), e.value);
      end
   endtask

   task automatic clearId();
      bus.id_valid      = 1'b0;
      bus.id_pc_plus4   = '0;
      bus.id_read_data1 = '0;
      bus.id_read_data2 = '0;
      bus.id_imm_ext    = '0;
      bus.id_rs         = '0;
      bus.id_rt         = '0;
      bus.id_rd         = '0;
      bus.id_uses_rt    = 1'b0;
      bus.id_reg_write  = 1'b0;
      bus.id_mem_to_reg = 1'b0;
      bus.id_mem_read   = 1'b0;
      bus.id_mem_write  = 1'b0;
      bus.id_branch     = 1'b0;
      bus.id_alu_src    = 1'b0;
      bus.id_reg_dst    = 1'b0;
      bus.id_alu_op     = '0;
   endtask

   task automatic wbOff();
      bus.wb_reg_write      = 1'b0;
      bus.wb_write_register = '0;
      bus.wb_write_data     = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rstS = 1'b0;
      busS.id_valid = 1'b0; busS.id_mem_read = 1'b0; busS.id_uses_rt = 1'b0;
      busS.id_rs = '0; busS.id_rt = '0; busS.id_rd = '0;
      busS.id_pc_plus4 = '0; busS.id_read_data1 = '0; busS.id_read_data2 = '0; busS.id_imm_ext = '0;
      busS.id_reg_write = 1'b0; busS.id_mem_to_reg = 1'b0; busS.id_mem_write = 1'b0;
      busS.id_branch = 1'b0; busS.id_alu_src = 1'b0; busS.id_reg_dst = 1'b0; busS.id_alu_op = '0;
      busS.wb_reg_write = 1'b0; busS.wb_write_register = '0; busS.wb_write_data = '0;
      busS.flush = 1'b0; busS.ex_hold = 1'b0;

      // Reset with live inputs and hold asserted: reset must win
      rst = 1'b0;
      clearId();
      wbOff();
      bus.flush = 1'b0;
      bus.ex_hold = 1'b1;
      bus.id_valid = 1'b1;
      bus.id_read_data1 = 32'h77;
      bus.id_alu_op = 4'h5;
      bus.id_pc_plus4 = 32'h1234;
      expectOut("rst_valid", S_VALID, 32'h0);
      expectOut("rst_rd1",   S_RD1,   32'h0);
      expectOut("rst_aluop", S_ALUOP, 32'h0);
      expectOut("rst_pc",    S_PC,    32'h0);
      expectOut("rst_bub",   S_BUB,   32'h0);
      step();
      checkVal("rst_stall_forced", 32'(bus.id_stall), 32'h0);

      // Plain capture
      rst = 1'b1;
      bus.ex_hold = 1'b0;
      clearId();
      bus.id_valid = 1'b1; bus.id_read_data1 = 32'h11; bus.id_read_data2 = 32'h22;
      bus.id_alu_op = ALU_ADD; bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
      bus.id_reg_write = 1'b1; bus.id_pc_plus4 = 32'h4;
      #1 checkVal("cap_stall", 32'(bus.id_stall), 32'h0);
      expectOut("cap_valid", S_VALID, 32'h1);
      expectOut("cap_rd1",   S_RD1,   32'h11);
      expectOut("cap_rd2",   S_RD2,   32'h22);
      expectOut("cap_aluop", S_ALUOP, 32'h2);
      step();

      // Load-use: lw rt=8 then add rs=8
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd8; bus.id_mem_read = 1'b1;
      bus.id_reg_write = 1'b1; bus.id_mem_to_reg = 1'b1; bus.id_alu_src = 1'b1;
      bus.id_alu_op = ALU_ADD; bus.id_read_data1 = 32'h100;
      expectOut("lw_valid", S_VALID, 32'h1);
      expectOut("lw_memr",  S_MEMR,  32'h1);
      expectOut("lw_rt",    S_RT,    32'h8);
      step();
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd8; bus.id_rt = 5'd3; bus.id_rd = 5'd4;
      bus.id_uses_rt = 1'b1; bus.id_reg_write = 1'b1; bus.id_reg_dst = 1'b1;
      bus.id_read_data1 = 32'h33; bus.id_read_data2 = 32'h44; bus.id_alu_op = ALU_ADD;
      #1 checkVal("lu_stall", 32'(bus.id_stall), 32'h1);
      expectOut("lu_bub_valid", S_VALID, 32'h0);
      expectOut("lu_bub_regw",  S_REGW,  32'h0);
      expectOut("lu_bub_aluop", S_ALUOP, 32'h0);
      expectOut("lu_bub_memr",  S_MEMR,  32'h0);
      expectOut("lu_bub_cnt",   S_BUB,   32'h1);
      step();
      checkVal("lu_stall_clear", 32'(bus.id_stall), 32'h0);
      expectOut("lu_add_valid", S_VALID, 32'h1);
      expectOut("lu_add_rd1",   S_RD1,   32'h33);
      expectOut("lu_add_rs",    S_RS,    32'h8);
      expectOut("lu_add_regw",  S_REGW,  32'h1);
      expectOut("lu_add_cnt",   S_BUB,   32'h1);
      step();

      // Load into r0 never stalls
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd0; bus.id_mem_read = 1'b1;
      expectOut("lw0_valid", S_VALID, 32'h1);
      expectOut("lw0_memr",  S_MEMR,  32'h1);
      expectOut("lw0_rt",    S_RT,    32'h0);
      step();
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b1;
      bus.id_read_data1 = 32'h21;
      #1 checkVal("lw0_stall", 32'(bus.id_stall), 32'h0);
      expectOut("lw0_add_valid", S_VALID, 32'h1);
      expectOut("lw0_add_rd1",   S_RD1,   32'h21);
      expectOut("lw0_cnt",       S_BUB,   32'h1);
      step();

      // WB bypass into capture
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd9; bus.id_rt = 5'd5;
      bus.id_read_data1 = 32'h0; bus.id_read_data2 = 32'h55;
      bus.wb_reg_write = 1'b1; bus.wb_write_register = 5'd9; bus.wb_write_data = 32'hDEAD;
      expectOut("byp_rs_rd1", S_RD1, 32'hDEAD);
      expectOut("byp_rs_rd2", S_RD2, 32'h55);
      step();
      bus.wb_write_register = 5'd0;
      bus.id_rs = 5'd0;
      expectOut("byp_r0_rd1", S_RD1, 32'h0);
      step();
      bus.id_rs = 5'd9; bus.id_read_data1 = 32'h7;
      bus.id_rt = 5'd12; bus.id_read_data2 = 32'h66;
      bus.wb_write_register = 5'd12; bus.wb_write_data = 32'hBEEF;
      expectOut("byp_rt_rd1", S_RD1, 32'h7);
      expectOut("byp_rt_rd2", S_RD2, 32'hBEEF);
      step();
      wbOff();

      // Hold for 3 cycles with WB refresh of r10 in cycle 2
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd10; bus.id_rt = 5'd11;
      bus.id_read_data1 = 32'h1; bus.id_read_data2 = 32'h2;
      bus.id_alu_op = ALU_SUB; bus.id_pc_plus4 = 32'h40; bus.id_reg_write = 1'b1;
      expectOut("hold_pre_rd1", S_RD1, 32'h1);
      expectOut("hold_pre_pc",  S_PC,  32'h40);
      step();
      bus.ex_hold = 1'b1;
      bus.id_rs = 5'd3; bus.id_read_data1 = 32'hAA; bus.id_read_data2 = 32'hBB;
      bus.id_alu_op = ALU_NOR; bus.id_pc_plus4 = 32'h99;
      for (int i = 1; i <= 3; i++) begin
         if (i == 2) begin
            bus.wb_reg_write = 1'b1; bus.wb_write_register = 5'd10; bus.wb_write_data = 32'h5;
         end else begin
            wbOff();
         end
         #1 checkVal($sformatf("hold%0d_stall", i), 32'(bus.id_stall), 32'h1);
         expectOut($sformatf("hold%0d_rd1", i),   S_RD1,   (i >= 2) ? 32'h5 : 32'h1);
         expectOut($sformatf("hold%0d_rd2", i),   S_RD2,   32'h2);
         expectOut($sformatf("hold%0d_aluop", i), S_ALUOP, 32'h6);
         expectOut($sformatf("hold%0d_pc", i),    S_PC,    32'h40);
         expectOut($sformatf("hold%0d_rs", i),    S_RS,    32'hA);
         expectOut($sformatf("hold%0d_valid", i), S_VALID, 32'h1);
         step();
      end
      wbOff();
      bus.ex_hold = 1'b0;

      // Flush with hold and load-use all active: one bubble
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd1; bus.id_rt = 5'd8; bus.id_mem_read = 1'b1;
      expectOut("fl_lw_valid", S_VALID, 32'h1);
      expectOut("fl_lw_memr",  S_MEMR,  32'h1);
      step();
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd8; bus.id_reg_write = 1'b1;
      bus.ex_hold = 1'b1; bus.flush = 1'b1;
      #1 checkVal("fl_stall", 32'(bus.id_stall), 32'h1);
      expectOut("fl_valid", S_VALID, 32'h0);
      expectOut("fl_regw",  S_REGW,  32'h0);
      expectOut("fl_memr",  S_MEMR,  32'h0);
      expectOut("fl_cnt",   S_BUB,   32'h2);
      step();
      bus.flush = 1'b0;
      bus.ex_hold = 1'b0;

      // Reset in the middle of a hold
      clearId();
      bus.id_valid = 1'b1; bus.id_rs = 5'd3; bus.id_read_data1 = 32'h77;
      bus.id_alu_op = ALU_ADD; bus.id_pc_plus4 = 32'h80; bus.id_reg_write = 1'b1;
      expectOut("rh_cap_valid", S_VALID, 32'h1);
      expectOut("rh_cap_rd1",   S_RD1,   32'h77);
      expectOut("rh_cap_cnt",   S_BUB,   32'h2);
      step();
      bus.ex_hold = 1'b1;
      expectOut("rh_hold_rd1", S_RD1, 32'h77);
      step();
      rst = 1'b0;
      expectOut("rh_valid", S_VALID, 32'h0);
      expectOut("rh_rd1",   S_RD1,   32'h0);
      expectOut("rh_aluop", S_ALUOP, 32'h0);
      expectOut("rh_pc",    S_PC,    32'h0);
      expectOut("rh_regw",  S_REGW,  32'h0);
      expectOut("rh_cnt",   S_BUB,   32'h0);
      step();
      checkVal("rh_stall_forced", 32'(bus.id_stall), 32'h0);
      rst = 1'b1;
      bus.ex_hold = 1'b0;
      bus.id_read_data1 = 32'h12;
      expectOut("rh_post_valid", S_VALID, 32'h1);
      expectOut("rh_post_rd1",   S_RD1,   32'h12);
      expectOut("rh_post_cnt",   S_BUB,   32'h0);
      step();

      // Saturating 2-bit bubble counter
      expectOut("sat_rst", S_BUBSAT, 32'h0);
      step();
      rstS = 1'b1;
      busS.flush = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         expectOut($sformatf("sat_bub%0d", n), S_BUBSAT, (n < 3) ? 32'(n) : 32'h3);
         step();
      end
      busS.flush = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
